// File: rtl/avfcl_acc_reader.sv
// avfcl_acc_reader
// Snapshots the AVF cross-layer accumulators on each epoch tick, pulses a clear
// back to them, then streams the snapshot out one word per accumulator over a
// valid/ready interface with even parity attached to every word.

module avfcl_acc_reader #(
    parameter int ACC_W   = 25,
    parameter int NUM_ACC = 6,
    parameter int EPOCH_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     epoch_tick,
    input  logic [NUM_ACC*ACC_W-1:0] acc_in,
    output logic                     acc_clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [2:0]               out_idx,
    output logic                     out_parity,
    output logic                     out_last,
    output logic [EPOCH_W-1:0]       epoch_cnt,
    output logic                     overrun
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_ACC - 1);

    state_t           state;
    state_t           next_state;
    logic [2:0]       idx;
    logic [2:0]       next_idx;
    logic [ACC_W-1:0] snap [NUM_ACC];
    logic             handshake;
    logic             final_hs;
    logic             take_snap;
    logic             drop_tick;
    logic             epoch_done;

    // A word is consumed when the consumer is ready while we are presenting one;
    // the final handshake is the one that completes the epoch.
    assign handshake = (state == SEND) && out_ready;
    assign final_hs  = handshake && (idx == LAST_IDX);

    // State and word index register; reset aborts any drain in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // Next-state logic: accept ticks in IDLE or on the final handshake, drop
    // (and flag) ticks that arrive while words are still pending.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        take_snap  = 1'b0;
        drop_tick  = 1'b0;
        epoch_done = 1'b0;
        case (state)
            IDLE: begin
                if (epoch_tick) begin
                    take_snap  = 1'b1;
                    next_state = SEND;
                    next_idx   = 3'd0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx == LAST_IDX) begin
                        epoch_done = 1'b1;
                        next_idx   = 3'd0;
                        if (epoch_tick) begin
                            take_snap  = 1'b1;
                            next_state = SEND;
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        next_idx = idx + 3'd1;
                    end
                end
                if (epoch_tick && !final_hs) begin
                    drop_tick = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = 3'd0;
            end
        endcase
    end

    // Snapshot bank: a raw copy of every accumulator slice taken on an accepted tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                snap[i] <= '0;
            end
        end else if (take_snap) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                snap[i] <= acc_in[i*ACC_W +: ACC_W];
            end
        end
    end

    // Clear pulse follows an accepted tick by one cycle so the accumulators
    // zero themselves right after their values were captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_clear <= 1'b0;
        end else begin
            acc_clear <= take_snap;
        end
    end

    // Completed-epoch counter; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_cnt <= '0;
        end else if (epoch_done) begin
            epoch_cnt <= epoch_cnt + EPOCH_W'(1);
        end
    end

    // Sticky overrun flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop_tick) begin
            overrun <= 1'b1;
        end
    end

    // Output word is a direct view of the snapshot at the current index, so it
    // stays stable for as long as the index is held under backpressure.
    always_comb begin
        out_valid  = (state == SEND);
        out_idx    = idx;
        out_data   = out_valid ? snap[idx] : '0;
        out_parity = ^out_data;
        out_last   = out_valid && (idx == LAST_IDX);
    end

endmodule

// File: tb/tb_avfcl_acc_reader.sv
// Bench for avfcl_acc_reader: directed epochs feed a scoreboard queue of
// expected words; a negedge monitor compares whatever the DUT presents.

module tb_avfcl_acc_reader;

    localparam int ACC_W      = 25;
    localparam int NUM_ACC    = 6;
    localparam int EPOCH_W_TB = 4;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [2:0]       idx;
        logic             par;
        logic             last;
    } word_t;

    logic                     clk;
    logic                     reset;
    logic                     epoch_tick;
    logic [NUM_ACC*ACC_W-1:0] acc_in;
    logic                     acc_clear;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_data;
    logic [2:0]               out_idx;
    logic                     out_parity;
    logic                     out_last;
    logic [EPOCH_W_TB-1:0]    epoch_cnt;
    logic                     overrun;

    word_t                    sb [$];
    word_t                    mon_w;
    logic [ACC_W-1:0]         cur_vals [NUM_ACC];
    logic [EPOCH_W_TB-1:0]    exp_epoch;
    logic                     exp_overrun;
    int                       exp_clears;
    int                       clear_seen;
    int                       n_pass;
    int                       n_total;

    avfcl_acc_reader #(
        .ACC_W  (ACC_W),
        .NUM_ACC(NUM_ACC),
        .EPOCH_W(EPOCH_W_TB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .epoch_tick(epoch_tick),
        .acc_in    (acc_in),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_parity(out_parity),
        .out_last  (out_last),
        .epoch_cnt (epoch_cnt),
        .overrun   (overrun)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic tick, input logic ready);
        epoch_tick = tick;
        out_ready  = ready;
        step();
    endtask

    task automatic loadAcc();
        for (int i = 0; i < NUM_ACC; i++) begin
            acc_in[i*ACC_W +: ACC_W] = cur_vals[i];
        end
    endtask

    task automatic pushEpoch();
        word_t w;
        for (int i = 0; i < NUM_ACC; i++) begin
            w.data = cur_vals[i];
            w.idx  = 3'(i);
            w.par  = ^cur_vals[i];
            w.last = (i == NUM_ACC - 1);
            sb.push_back(w);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            step();
            n++;
        end
        checkOutput("drain_bound", (n < 100), 1);
    endtask

    task automatic runEpoch();
        loadAcc();
        pushEpoch();
        applyStimulus(1'b1, 1'b1);
        epoch_tick = 1'b0;
        waitDrain();
        exp_epoch  = exp_epoch + 1'b1;
        exp_clears = exp_clears + 1;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_epoch"}, epoch_cnt, exp_epoch);
        checkOutput({tag, "_overrun"}, overrun, exp_overrun);
        checkOutput({tag, "_clears"}, clear_seen, exp_clears);
    endtask

    // Monitor: every presented word is compared with the queue head, and the
    // head is retired only when the consumer accepts it.
    always @(negedge clk) begin
        if (!reset) begin
            if (acc_clear) clear_seen++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", {29'd0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    mon_w = sb[0];
                    checkOutput("word_data", out_data, mon_w.data);
                    checkOutput("word_idx", out_idx, mon_w.idx);
                    checkOutput("word_parity", out_parity, mon_w.par);
                    checkOutput("word_last", out_last, mon_w.last);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [ACC_W-1:0] t2_par_exp [NUM_ACC];
        word_t w;
        n_pass      = 0;
        n_total     = 0;
        clear_seen  = 0;
        exp_clears  = 0;
        exp_epoch   = '0;
        exp_overrun = 1'b0;
        reset       = 1'b1;
        epoch_tick  = 1'b0;
        out_ready   = 1'b0;
        acc_in      = '0;
        step();
        step();
        reset = 1'b0;

        // Test 1: idle after reset.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("t1_valid", out_valid, 0);
        checkOutput("t1_clear", acc_clear, 0);
        checkOutput("t1_data", out_data, 0);
        checkStatus("t1");

        // Test 2: simple epoch with hand-computed parity 1,1,0,1,0,0.
        t2_par_exp = '{1, 1, 0, 1, 0, 0};
        for (int i = 0; i < NUM_ACC; i++) begin
            cur_vals[i] = ACC_W'(i + 1);
            w.data = cur_vals[i];
            w.idx  = 3'(i);
            w.par  = t2_par_exp[i][0];
            w.last = (i == NUM_ACC - 1);
            sb.push_back(w);
        end
        loadAcc();
        applyStimulus(1'b1, 1'b1);
        epoch_tick = 1'b0;
        checkOutput("t2_clear_t1", acc_clear, 1);
        checkOutput("t2_valid_t1", out_valid, 1);
        step();
        checkOutput("t2_clear_t2", acc_clear, 0);
        waitDrain();
        exp_epoch  = exp_epoch + 1'b1;
        exp_clears = exp_clears + 1;
        checkStatus("t2");

        // Test 3: backpressure for 5 cycles at idx2.
        cur_vals = '{25'h0ABCDE, 25'h1000001, 25'h0123456, 25'h1FEDCBA, 25'h0000007, 25'h1555555};
        loadAcc();
        pushEpoch();
        applyStimulus(1'b1, 1'b1);
        epoch_tick = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("t3_hold_idx", out_idx, 2);
        checkOutput("t3_hold_valid", out_valid, 1);
        checkOutput("t3_hold_data", out_data, 25'h0123456);
        out_ready = 1'b1;
        waitDrain();
        exp_epoch  = exp_epoch + 1'b1;
        exp_clears = exp_clears + 1;
        checkStatus("t3");

        // Test 4: tick at idx3 is dropped and flags overrun.
        cur_vals = '{25'd100, 25'd200, 25'd300, 25'd400, 25'd500, 25'd600};
        loadAcc();
        pushEpoch();
        applyStimulus(1'b1, 1'b1);
        epoch_tick = 1'b0;
        step();
        step();
        step();
        checkOutput("t4_at_idx3", out_idx, 3);
        acc_in = '1;
        applyStimulus(1'b1, 1'b1);
        epoch_tick  = 1'b0;
        exp_overrun = 1'b1;
        checkOutput("t4_no_clear", acc_clear, 0);
        waitDrain();
        exp_epoch  = exp_epoch + 1'b1;
        exp_clears = exp_clears + 1;
        checkStatus("t4a");
        cur_vals = '{25'd9, 25'd8, 25'd7, 25'd6, 25'd5, 25'd4};
        runEpoch();
        checkStatus("t4b");

        // Test 5: tick on the final handshake chains straight into a new epoch.
        cur_vals = '{25'h11, 25'h22, 25'h33, 25'h44, 25'h55, 25'h66};
        loadAcc();
        pushEpoch();
        applyStimulus(1'b1, 1'b1);
        epoch_tick = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checkOutput("t5_at_last", out_last, 1);
        cur_vals = '{25'h0F0F0F, 25'h1F0000, 25'h000F00, 25'h1, 25'h3, 25'h1FFFFFE};
        loadAcc();
        pushEpoch();
        applyStimulus(1'b1, 1'b1);
        epoch_tick = 1'b0;
        exp_epoch  = exp_epoch + 1'b1;
        exp_clears = exp_clears + 2;
        checkOutput("t5_clear", acc_clear, 1);
        checkOutput("t5_no_gap", out_valid, 1);
        checkOutput("t5_idx0", out_idx, 0);
        checkOutput("t5_epoch_mid", epoch_cnt, exp_epoch);
        waitDrain();
        exp_epoch = exp_epoch + 1'b1;
        checkStatus("t5");

        // Test 6: all-ones data, epoch counter wrap, then reset mid-drain.
        for (int i = 0; i < NUM_ACC; i++) cur_vals[i] = 25'h1FFFFFF;
        while (exp_epoch != 4'hF) runEpoch();
        checkOutput("t6_epoch_max", epoch_cnt, 4'hF);
        runEpoch();
        checkOutput("t6_epoch_wrap", epoch_cnt, 0);
        checkStatus("t6");
        loadAcc();
        pushEpoch();
        applyStimulus(1'b1, 1'b1);
        epoch_tick = 1'b0;
        step();
        step();
        reset     = 1'b1;
        out_ready = 1'b0;
        step();
        sb.delete();
        reset       = 1'b0;
        exp_epoch   = '0;
        exp_overrun = 1'b0;
        checkOutput("t6_rst_valid", out_valid, 0);
        checkOutput("t6_rst_idx", out_idx, 0);
        checkOutput("t6_rst_data", out_data, 0);
        checkOutput("t6_rst_parity", out_parity, 0);
        checkOutput("t6_rst_last", out_last, 0);
        checkOutput("t6_rst_clear", acc_clear, 0);
        checkOutput("t6_rst_epoch", epoch_cnt, 0);
        checkOutput("t6_rst_overrun", overrun, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("t6_post_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
